// File: rtl/chunked_serial_adder.sv
// Multi-cycle adder/subtractor: processes WIDTH-bit operands CHUNK bits per clock, LSB chunk first.
// Optional build macro ADDER_SATURATE_EN makes s clamp to the signed limit on overflow.
module chunked_serial_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             c_out,
  output logic             ovf,
  output logic             busy
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry;
  logic [KW-1:0]    k;

  logic [CHUNK:0]   chunk_sum;
  logic             last;
  logic             ovf_next;
  logic [WIDTH-1:0] sat_value;

  // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
  always_comb begin
    chunk_sum = {1'b0, a_q[k*CHUNK +: CHUNK]} + {1'b0, b_q[k*CHUNK +: CHUNK]}
              + {{CHUNK{1'b0}}, carry};
    last      = (k == KW'(NCHUNK - 1));
    // Signed overflow: operand signs agree but the result sign differs (same as carry-in XOR carry-out of the MSB).
    ovf_next  = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (chunk_sum[CHUNK-1] != a_q[WIDTH-1]);
    // Overflow direction follows the shared operand sign.
    sat_value = {a_q[WIDTH-1], {(WIDTH-1){~a_q[WIDTH-1]}}};
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      carry     <= 1'b0;
      k         <= '0;
      s         <= '0;
      c_out     <= 1'b0;
      ovf       <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q      <= a;
            // Subtract as A + ~B + ~borrow.
            b_q      <= mode ? ~b : b;
            carry    <= mode ^ c_in;
            k        <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          s[k*CHUNK +: CHUNK] <= chunk_sum[CHUNK-1:0];
          carry               <= chunk_sum[CHUNK];
          if (last) begin
            c_out     <= chunk_sum[CHUNK];
            ovf       <= ovf_next;
`ifdef ADDER_SATURATE_EN
            if (ovf_next) s <= sat_value;
`endif
            k         <= '0;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            k <= k + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chunked_serial_adder.sv
// Scoreboard bench for chunked_serial_adder: expected results are queued at drive time and
// compared when out_valid appears. Build with +define+ADDER_SATURATE_EN to check the clamping variant.
module tb_chunked_serial_adder;

  localparam int WIDTH  = 16;
  localparam int CHUNK  = 4;
  localparam int NCHUNK = WIDTH / CHUNK;

  typedef struct {
    logic [WIDTH-1:0] s;
    logic             c_out;
    logic             ovf;
  } result_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             mode = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             c_in = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] s;
  logic             c_out;
  logic             ovf;
  logic             busy;

  int      checks = 0;
  int      errors = 0;
  result_t sb_q[$];

  chunked_serial_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .a(a), .b(b), .c_in(c_in), .out_valid(out_valid),
    .out_ready(out_ready), .s(s), .c_out(c_out), .ovf(ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model in plain integer arithmetic.
  function automatic result_t model(input logic m, input logic [WIDTH-1:0] x,
                                    input logic [WIDTH-1:0] y, input logic ci);
    result_t r;
    longint  ux = longint'(x);
    longint  uy = longint'(y);
    longint  sx = longint'($signed(x));
    longint  sy = longint'($signed(y));
    longint  full;
    longint  sres;
    if (!m) begin
      full    = ux + uy + longint'(ci);
      r.c_out = (full >= (64'sd1 <<< WIDTH));
      sres    = sx + sy + longint'(ci);
    end else begin
      full    = ux - uy - longint'(ci);
      r.c_out = (ux >= uy + longint'(ci));
      sres    = sx - sy - longint'(ci);
    end
    r.s   = full[WIDTH-1:0];
    r.ovf = (sres > (64'sd1 <<< (WIDTH-1)) - 1) || (sres < -(64'sd1 <<< (WIDTH-1)));
`ifdef ADDER_SATURATE_EN
    if (r.ovf) r.s = (sres > 0) ? {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-1){1'b0}}};
`endif
    return r;
  endfunction

  // One full transaction; 'hold' cycles of back-pressure in DONE while in_valid/a toggle.
  task automatic run_op(input logic m, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                        input logic ci, input int hold);
    result_t exp;
    int      lat;
    check("in_ready_before_accept", in_ready, 1'b1);
    sb_q.push_back(model(m, x, y, ci));
    mode = m; a = x; b = y; c_in = ci; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    // Scramble operands after accept: they must not matter any more.
    a = $urandom; b = $urandom; mode = ~m; c_in = ~ci;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!out_valid && lat < 200);
    check("latency", lat, NCHUNK);
    if (!out_valid) begin
      $display("FAIL out_valid_timeout: got 0 expected 1");
      errors++;
      checks++;
      void'(sb_q.pop_front());
      return;
    end
    exp = sb_q.pop_front();
    check("s", s, exp.s);
    check("c_out", c_out, exp.c_out);
    check("ovf", ovf, exp.ovf);
    check("busy_done", busy, 1'b1);
    for (int i = 0; i < hold; i++) begin
      in_valid = i[0];
      a = $urandom;
      @(posedge clk); #1;
      check("hold_s", s, exp.s);
      check("hold_c_out", c_out, exp.c_out);
      check("hold_ovf", ovf, exp.ovf);
      check("hold_in_ready", in_ready, 1'b0);
      check("hold_out_valid", out_valid, 1'b1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("out_valid_drop", out_valid, 1'b0);
    check("in_ready_back", in_ready, 1'b1);
    check("busy_idle", busy, 1'b0);
  endtask

  initial begin
    #12;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_s", s, '0);
    check("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(1'b0, 16'd100, 16'd111, 1'b0, 0);
    run_op(1'b0, 16'hFFFF, 16'h0001, 1'b0, 0);
    run_op(1'b0, 16'h7FFF, 16'h0001, 1'b0, 0);
    run_op(1'b0, 16'h8000, 16'h8000, 1'b1, 0);
    run_op(1'b1, 16'd111, 16'd100, 1'b0, 0);
    run_op(1'b1, 16'd0, 16'd1, 1'b0, 0);
    run_op(1'b1, 16'h8000, 16'h0001, 1'b0, 0);
    run_op(1'b1, 16'd5, 16'd4, 1'b1, 0);
    run_op(1'b1, 16'd5, 16'd5, 1'b1, 0);
    run_op(1'b0, 16'h1234, 16'h4321, 1'b1, 5);

    // Reset during RUN with chunk 2 pending.
    mode = 1'b0; a = 16'hFFFF; b = 16'hFFFF; c_in = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("arst_s", s, '0);
    check("arst_c_out", c_out, 1'b0);
    check("arst_ovf", ovf, 1'b0);
    check("arst_in_ready", in_ready, 1'b1);
    check("arst_busy", busy, 1'b0);
    check("arst_out_valid", out_valid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < NCHUNK + 3; i++) begin
      @(posedge clk); #1;
      check("post_rst_out_valid", out_valid, 1'b0);
      check("post_rst_in_ready", in_ready, 1'b1);
    end

    for (int i = 0; i < 40; i++)
      run_op(1'($urandom), WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 0);

    check("scoreboard_empty", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
